// File: rtl/amp_limit_pkg.sv
// Shared defaults and repeat-FSM state type for the amplitude limit adjuster.
package amp_limit_pkg;

   localparam int unsigned DEF_WIDTH        = 12;
   localparam int unsigned DEF_STEP         = 124;
   localparam int unsigned DEF_MAX_LIMIT    = 4092;
   localparam int unsigned DEF_MIN_GAP      = 124;
   localparam int unsigned DEF_REPEAT_DELAY = 4;
   localparam int unsigned DEF_REPEAT_RATE  = 1;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } rep_state_t;

endpackage

// File: rtl/press_repeat.sv
// Hold-to-repeat press tracker: one step on press, then auto-repeat after a delay.
module press_repeat
   import amp_limit_pkg::*;
#(
   parameter int unsigned KEY_W        = 3,
   parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             tick,
   input  logic             req,
   input  logic [KEY_W-1:0] key,
   output logic             step_c
);

   localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   rep_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [KEY_W-1:0] key_q, key_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         key_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
      end
   end

   // A changed key while holding is treated exactly like a fresh press.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      step_c  = 1'b0;
      if (tick) begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  step_c  = 1'b1;
                  cnt_d   = CNT_W'(REPEAT_DELAY);
                  key_d   = key;
                  state_d = DELAY;
               end
            end
            DELAY, REPEAT: begin
               if (!req) begin
                  state_d = IDLE;
               end else if (key != key_q) begin
                  step_c  = 1'b1;
                  cnt_d   = CNT_W'(REPEAT_DELAY);
                  key_d   = key;
                  state_d = DELAY;
               end else if (cnt_q == CNT_W'(1)) begin
                  step_c  = 1'b1;
                  cnt_d   = CNT_W'(REPEAT_RATE);
                  state_d = REPEAT;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: rtl/amp_limit_adjuster.sv
// Per-channel min/max DAC limit registers with saturating, gap-preserving button steps.
module amp_limit_adjuster
   import amp_limit_pkg::*;
#(
   parameter int unsigned WIDTH        = DEF_WIDTH,
   parameter int unsigned CHANNELS     = 2,
   parameter int unsigned STEP         = DEF_STEP,
   parameter int unsigned MAX_LIMIT    = DEF_MAX_LIMIT,
   parameter int unsigned MIN_GAP      = DEF_MIN_GAP,
   parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE,
   localparam int unsigned SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      tick,
   input  logic                      increase,
   input  logic                      decrease,
   input  logic                      minOrMax,
   input  logic [SEL_W-1:0]          channel_sel,
   output logic [CHANNELS*WIDTH-1:0] maximum,
   output logic [CHANNELS*WIDTH-1:0] minimum,
   output logic                      changed,
   output logic                      limit_hit
);

   localparam int unsigned EXT_W = WIDTH + 1;
   localparam int unsigned KEY_W = SEL_W + 2;
   localparam logic [EXT_W-1:0] STEP_X = EXT_W'(STEP);
   localparam logic [EXT_W-1:0] LIM_X  = EXT_W'(MAX_LIMIT);
   localparam logic [EXT_W-1:0] GAP_X  = EXT_W'(MIN_GAP);

   logic [WIDTH-1:0] max_q [CHANNELS];
   logic [WIDTH-1:0] min_q [CHANNELS];
   logic             req_c, step_c;
   logic [KEY_W-1:0] key_c;
   logic [EXT_W-1:0] cur_max, cur_min, cur_val, gap, up_val, dn_val, nxt_val;

   assign req_c = (increase ^ decrease) && (32'(channel_sel) < CHANNELS);
   assign key_c = {increase, minOrMax, channel_sel};

   press_repeat #(
      .KEY_W        (KEY_W),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
   ) u_press_repeat (
      .clock  (clock),
      .reset  (reset),
      .tick   (tick),
      .req    (req_c),
      .key    (key_c),
      .step_c (step_c)
   );

   // Saturating step for the selected field; WIDTH+1 bits so nothing wraps.
   always_comb begin
      cur_max = '0;
      cur_min = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (SEL_W'(c) == channel_sel) begin
            cur_max = {1'b0, max_q[c]};
            cur_min = {1'b0, min_q[c]};
         end
      end
      gap     = cur_max - cur_min;
      cur_val = minOrMax ? cur_max : cur_min;
      up_val  = cur_val + STEP_X;
      dn_val  = (cur_val < STEP_X) ? '0 : cur_val - STEP_X;
      nxt_val = cur_val;
      if (minOrMax) begin
         if (increase)
            nxt_val = (up_val > LIM_X) ? LIM_X : up_val;
         else if (gap > GAP_X)
            nxt_val = (dn_val < cur_min + GAP_X) ? cur_min + GAP_X : dn_val;
      end else begin
         if (increase) begin
            if (gap > GAP_X)
               nxt_val = (up_val > cur_max - GAP_X) ? cur_max - GAP_X : up_val;
         end else begin
            nxt_val = dn_val;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < CHANNELS; c++) begin
            max_q[c] <= WIDTH'(MAX_LIMIT);
            min_q[c] <= '0;
         end
         changed   <= 1'b0;
         limit_hit <= 1'b0;
      end else begin
         changed   <= 1'b0;
         limit_hit <= 1'b0;
         if (step_c) begin
            changed   <= (nxt_val != cur_val);
            limit_hit <= (nxt_val == cur_val);
            for (int c = 0; c < CHANNELS; c++) begin
               if (SEL_W'(c) == channel_sel) begin
                  if (minOrMax) max_q[c] <= nxt_val[WIDTH-1:0];
                  else          min_q[c] <= nxt_val[WIDTH-1:0];
               end
            end
         end
      end
   end

   always_comb begin
      maximum = '0;
      minimum = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         maximum[c*WIDTH +: WIDTH] = max_q[c];
         minimum[c*WIDTH +: WIDTH] = min_q[c];
      end
   end

endmodule
